// File: rtl/gt_cache_pkg.sv
// Shared types and constants for the direct-mapped + victim cache controller.
package gt_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    // Byte-offset bits inside one cache line
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SWAP,
        WB_REQ,
        FETCH_REQ,
        FETCH_WAIT,
        FILL,
        RESP
    } state_t;

    // Clear the byte-offset bits so the address points at the start of its line
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/gt_sat_counter.sv
// Saturating event counter, cleared only by reset.
module gt_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] value_reg;

    // Count up on inc, holding at the all-ones ceiling
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value_reg <= '0;
        end else if (inc && (value_reg != CNT_MAX)) begin
            value_reg <= value_reg + CNT_ONE;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/gt_miss_ctrl.sv
// Lookup / swap / writeback / fetch sequencer for a direct-mapped cache
// backed by a victim cache, with hit and miss statistics.
module gt_miss_ctrl
    import gt_cache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic [ADDR_W-1:0] lookup_addr,
    input  logic              dm_hit,
    input  logic              vc_hit,
    input  logic              vc_evict_dirty,
    input  logic [ADDR_W-1:0] vc_evict_addr,
    input  logic [LINE_W-1:0] vc_evict_data,
    output logic              swap_en,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] lookup_addr_reg;
    logic [ADDR_W-1:0] evict_addr_reg;
    logic [LINE_W-1:0] evict_data_reg;
    logic [LINE_W-1:0] fill_data_reg;
    logic              resp_hit_reg;
    logic              hit_inc;
    logic              miss_inc;

    // State register; reset aborts any transaction in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; a direct-map hit wins over a victim hit
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (req_valid) state_next = LOOKUP;
            LOOKUP: begin
                if (dm_hit)              state_next = RESP;
                else if (vc_hit)         state_next = SWAP;
                else if (vc_evict_dirty) state_next = WB_REQ;
                else                     state_next = FETCH_REQ;
            end
            SWAP:       state_next = RESP;
            WB_REQ:     if (mem_req_ready) state_next = FETCH_REQ;
            FETCH_REQ:  if (mem_req_ready) state_next = FETCH_WAIT;
            FETCH_WAIT: if (mem_rsp_valid) state_next = FILL;
            FILL:       state_next = RESP;
            RESP:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Latch request address, lookup outcome, evicted victim line and fetched line
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lookup_addr_reg <= '0;
            evict_addr_reg  <= '0;
            evict_data_reg  <= '0;
            fill_data_reg   <= '0;
            resp_hit_reg    <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && req_valid) begin
                lookup_addr_reg <= req_addr;
            end
            if (state_reg == LOOKUP) begin
                resp_hit_reg <= dm_hit | vc_hit;
                if (!dm_hit && !vc_hit) begin
                    evict_addr_reg <= vc_evict_addr;
                    evict_data_reg <= vc_evict_data;
                end
            end
            if ((state_reg == FETCH_WAIT) && mem_rsp_valid) begin
                fill_data_reg <= mem_rsp_data;
            end
        end
    end

    // Moore outputs decoded from the current state and latched registers
    always_comb begin
        req_ready     = 1'b0;
        swap_en       = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        fill_valid    = 1'b0;
        resp_valid    = 1'b0;
        case (state_reg)
            IDLE:      req_ready = 1'b1;
            SWAP:      swap_en   = 1'b1;
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = line_align(evict_addr_reg);
                mem_req_data  = evict_data_reg;
            end
            FETCH_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_align(lookup_addr_reg);
            end
            FILL:      fill_valid = 1'b1;
            RESP:      resp_valid = 1'b1;
            default:   ;
        endcase
    end

    assign lookup_addr = lookup_addr_reg;
    assign fill_addr   = line_align(lookup_addr_reg);
    assign fill_data   = fill_data_reg;
    assign resp_hit    = resp_hit_reg;

    // Victim hits count as hits: the line is still served from the cache
    assign hit_inc  = (state_reg == LOOKUP) && (dm_hit || vc_hit);
    assign miss_inc = (state_reg == LOOKUP) && !dm_hit && !vc_hit;

    gt_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (hit_inc),
        .value (hit_cnt)
    );

    gt_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (miss_inc),
        .value (miss_cnt)
    );

endmodule

// File: tb/tb_gt_miss_ctrl.sv
// Directed self-checking bench for gt_miss_ctrl with a transaction-level model.
module tb_gt_miss_ctrl;
    import gt_cache_pkg::*;

    localparam int SCNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              dm_hit, vc_hit, vc_evict_dirty;
    logic [ADDR_W-1:0] vc_evict_addr;
    logic [LINE_W-1:0] vc_evict_data;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;

    logic              req_ready, swap_en, mem_req_valid, mem_req_we;
    logic              fill_valid, resp_valid, resp_hit;
    logic [ADDR_W-1:0] lookup_addr, mem_req_addr, fill_addr;
    logic [LINE_W-1:0] mem_req_data, fill_data;
    logic [31:0]       hit_cnt, miss_cnt;

    logic              s_req_ready, s_swap_en, s_mem_req_valid, s_mem_req_we;
    logic              s_fill_valid, s_resp_valid, s_resp_hit;
    logic [ADDR_W-1:0] s_lookup_addr, s_mem_req_addr, s_fill_addr;
    logic [LINE_W-1:0] s_mem_req_data, s_fill_data;
    logic [SCNT_W-1:0] s_hit_cnt, s_miss_cnt;

    always #5 clk = ~clk;

    gt_miss_ctrl #(.CNT_W(32)) dut (
        .CLK(clk), .RST_N(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .lookup_addr(lookup_addr), .dm_hit(dm_hit), .vc_hit(vc_hit),
        .vc_evict_dirty(vc_evict_dirty), .vc_evict_addr(vc_evict_addr),
        .vc_evict_data(vc_evict_data), .swap_en(swap_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .fill_valid(fill_valid),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly
    gt_miss_ctrl #(.CNT_W(SCNT_W)) sat_dut (
        .CLK(clk), .RST_N(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(s_req_ready),
        .lookup_addr(s_lookup_addr), .dm_hit(dm_hit), .vc_hit(vc_hit),
        .vc_evict_dirty(vc_evict_dirty), .vc_evict_addr(vc_evict_addr),
        .vc_evict_data(vc_evict_data), .swap_en(s_swap_en),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(s_mem_req_we), .mem_req_addr(s_mem_req_addr),
        .mem_req_data(s_mem_req_data), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .fill_valid(s_fill_valid),
        .fill_addr(s_fill_addr), .fill_data(s_fill_data),
        .resp_valid(s_resp_valid), .resp_hit(s_resp_hit),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    // ---------------- model state ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [255:0] data;
    } mreq_t;

    mreq_t        mq[$];          // memory requests still expected, in order
    bit           hs_we[$];       // we bit of each accepted memory request
    longint       exp_hit, exp_miss;
    bit           exp_resp_hit;
    logic [31:0]  exp_fill_addr;
    logic [255:0] exp_fill_data;
    logic [31:0]  obs_fill_addr;
    int           swap_seen, fill_seen, resp_seen, mem_seen;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [31:0] align_model(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint cap = (longint'(1) << w) - 1;
        return (v > cap) ? cap : v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (mem_req_valid) begin
            mem_seen++;
            if (mq.size() == 0) begin
                check32("mem_req_unexpected", 32'(mem_req_valid), 32'(0));
            end else begin
                check32("mem_req_we", 32'(mem_req_we), 32'(mq[0].we));
                check32("mem_req_addr", mem_req_addr, mq[0].addr);
                if (mq[0].we) check256("mem_req_data", mem_req_data, mq[0].data);
                if (mem_req_ready) begin
                    hs_we.push_back(mem_req_we);
                    void'(mq.pop_front());
                end
            end
        end
        if (swap_en) swap_seen++;
        if (fill_valid) begin
            fill_seen++;
            obs_fill_addr = fill_addr;
            check32("fill_addr", fill_addr, exp_fill_addr);
            check256("fill_data", fill_data, exp_fill_data);
        end
        if (resp_valid) begin
            resp_seen++;
            check32("resp_hit", 32'(resp_hit), 32'(exp_resp_hit));
        end
        if (s_resp_valid) check32("sat_resp_hit", 32'(s_resp_hit), 32'(exp_resp_hit));
        if (req_ready) begin
            check32("hit_cnt", hit_cnt, 32'(sat(exp_hit, 32)));
            check32("miss_cnt", miss_cnt, 32'(sat(exp_miss, 32)));
        end
        if (s_req_ready) begin
            check32("sat_hit_cnt", 32'(s_hit_cnt), 32'(sat(exp_hit, SCNT_W)));
            check32("sat_miss_cnt", 32'(s_miss_cnt), 32'(sat(exp_miss, SCNT_W)));
        end
    end

    // ---------------- one request, driven and bounded ----------------
    task automatic run_txn(input string tag, input logic [31:0] addr, input bit dm, input bit vc,
                           input bit dirty, input logic [31:0] eaddr, input logic [255:0] edata,
                           input int rwait, input int rdelay, input logic [255:0] rdata,
                           input bit poke, input bit abort_wait);
        mreq_t m;
        int    exp_lat;
        int    lat;
        int    wcnt;
        int    rcnt;
        bit    armed;
        bit    got;
        bit    is_miss;

        is_miss      = !dm && !vc;
        exp_resp_hit = dm | vc;
        swap_seen = 0; fill_seen = 0; resp_seen = 0; mem_seen = 0;
        hs_we.delete();
        if (is_miss) begin
            exp_lat = 1 + (rwait + 1) + (rdelay + 1) + 1 + 1;
            if (dirty) begin
                m.we = 1'b1; m.addr = align_model(eaddr); m.data = edata;
                mq.push_back(m);
                exp_lat += rwait + 1;
            end
            m.we = 1'b0; m.addr = align_model(addr); m.data = '0;
            mq.push_back(m);
            exp_fill_addr = align_model(addr);
            exp_fill_data = rdata;
        end else begin
            exp_lat = 2 + ((!dm && vc) ? 1 : 0);
        end

        @(posedge clk); #1;
        check32({tag, "_idle_ready"}, 32'(req_ready), 32'(1));
        req_valid = 1'b1; req_addr = addr;
        dm_hit = dm; vc_hit = vc; vc_evict_dirty = dirty;
        vc_evict_addr = eaddr; vc_evict_data = edata;
        @(posedge clk); #1;           // acceptance edge E0 has passed
        req_valid = poke;
        if (poke) req_addr = 32'hDEAD_BEE0;
        if (is_miss) exp_miss++; else exp_hit++;

        wcnt = 0; rcnt = rdelay; armed = 1'b0; got = 1'b0; lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_valid = 1'b0;
            if (abort_wait && armed) begin
                rst_n = 1'b0;
                mq.delete();
                exp_hit = 0; exp_miss = 0;
                exp_fill_data = '0; exp_fill_addr = '0;
                mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
                #1;
                check32("abort_mem_req_valid", 32'(mem_req_valid), 32'(0));
                check32("abort_req_ready", 32'(req_ready), 32'(1));
                check32("abort_resp_valid", 32'(resp_valid), 32'(0));
                got = 1'b1;
                break;
            end
            if (resp_valid) begin
                lat = k + 1;
                got = 1'b1;
                break;
            end
            if (armed) begin
                if (rcnt == 0) begin
                    mem_rsp_valid = 1'b1; mem_rsp_data = rdata; armed = 1'b0;
                end else begin
                    rcnt--;
                end
            end else begin
                mem_rsp_valid = 1'b0;
            end
            if (mem_req_valid) begin
                if (wcnt >= rwait) begin
                    mem_req_ready = 1'b1; wcnt = 0;
                    if (!mem_req_we) begin armed = 1'b1; rcnt = rdelay; end
                end else begin
                    mem_req_ready = 1'b0; wcnt++;
                end
            end else begin
                mem_req_ready = 1'b0;
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check32({tag, "_completed"}, 32'(got), 32'(1));

        if (abort_wait) begin
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk); #1;
            check32("abort_no_resp", 32'(resp_seen), 32'(0));
            check32("abort_no_fill", 32'(fill_seen), 32'(0));
            check32("abort_hit_cnt", hit_cnt, 32'(0));
            check32("abort_miss_cnt", miss_cnt, 32'(0));
        end else begin
            @(negedge clk); #1;
            check32({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            check32({tag, "_resp_count"}, 32'(resp_seen), 32'(1));
            check32({tag, "_swap_count"}, 32'(swap_seen), 32'((!dm && vc) ? 1 : 0));
            check32({tag, "_fill_count"}, 32'(fill_seen), 32'(is_miss ? 1 : 0));
            check32({tag, "_mem_left"}, 32'(mq.size()), 32'(0));
            check32({tag, "_lookup_addr"}, lookup_addr, addr);
        end
        $display("txn %s addr=%h dm=%0d vc=%0d dirty=%0d lat=%0d hit_cnt=%0d miss_cnt=%0d",
                 tag, addr, dm, vc, dirty, lat, hit_cnt, miss_cnt);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [255:0] a5_line;
        logic [255:0] wb_line;
        a5_line = {32{8'hA5}};
        wb_line = {8{32'hC0DE_0001}};

        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0;
        dm_hit = 1'b0; vc_hit = 1'b0; vc_evict_dirty = 1'b0;
        vc_evict_addr = '0; vc_evict_data = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        exp_hit = 0; exp_miss = 0; exp_resp_hit = 1'b0;
        exp_fill_addr = '0; exp_fill_data = '0; obs_fill_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        check32("rst_req_ready", 32'(req_ready), 32'(1));
        check32("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
        check32("rst_pulses", {29'd0, swap_en, fill_valid, resp_valid}, 32'(0));
        check32("rst_lookup_addr", lookup_addr, 32'(0));
        check32("rst_hit_cnt", hit_cnt, 32'(0));
        check32("rst_miss_cnt", miss_cnt, 32'(0));
        check256("rst_fill_data", fill_data, '0);
        rst_n = 1'b1;
        $display("txn reset released");

        // Direct-map hit
        run_txn("dm_hit", 32'h0000_1234, 1, 0, 0, 32'h0, '0, 0, 0, '0, 0, 0);
        check32("dm_hit_cnt_literal", hit_cnt, 32'd1);
        check32("dm_hit_no_mem", 32'(mem_seen), 32'(0));

        // Victim hit
        run_txn("vc_hit", 32'h0000_2040, 0, 1, 0, 32'h0, '0, 0, 0, '0, 0, 0);
        check32("vc_hit_miss_cnt_literal", miss_cnt, 32'd0);
        check32("vc_hit_cnt_literal", hit_cnt, 32'd2);

        // Clean miss, memory stalls the request for 3 cycles
        run_txn("clean_miss", 32'h0000_305F, 0, 0, 0, 32'h0000_9000, '0, 3, 2, a5_line, 0, 0);
        check32("clean_fill_addr_literal", obs_fill_addr, 32'h0000_3040);
        check256("clean_fill_data_literal", fill_data, a5_line);
        check32("clean_miss_cnt_literal", miss_cnt, 32'd1);

        // Dirty miss: writeback must complete before the fetch
        run_txn("dirty_miss", 32'h0000_8123, 0, 0, 1, 32'h0000_7000, wb_line, 1, 0, {8{32'h1357_9BDF}}, 0, 0);
        check32("dirty_handshakes", 32'(hs_we.size()), 32'd2);
        if (hs_we.size() == 2) begin
            check32("dirty_first_is_wb", 32'(hs_we[0]), 32'd1);
            check32("dirty_second_is_fetch", 32'(hs_we[1]), 32'd0);
        end

        // Stray memory response while idle must be ignored
        fill_seen = 0; resp_seen = 0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = {32{8'h3C}};
        repeat (2) @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk); #1;
        check32("stray_no_fill", 32'(fill_seen), 32'(0));
        check32("stray_no_resp", 32'(resp_seen), 32'(0));
        check32("stray_req_ready", 32'(req_ready), 32'(1));
        check256("stray_fill_data_kept", fill_data, exp_fill_data);
        $display("txn stray_rsp ignored fill_seen=%0d resp_seen=%0d", fill_seen, resp_seen);

        // Second request presented while busy must not replace the latched one
        run_txn("busy_poke", 32'h0000_4444, 1, 0, 0, 32'h0, '0, 0, 0, '0, 1, 0);

        // Reset during FETCH_WAIT aborts the miss
        run_txn("abort", 32'h0000_5000, 0, 0, 0, 32'h0000_6000, '0, 0, 5, {8{32'hFFFF_0000}}, 0, 1);

        // Saturation on the narrow copy; both-hit case takes the direct-map path
        run_txn("sat_h1", 32'h0000_0100, 1, 0, 0, 32'h0, '0, 0, 0, '0, 0, 0);
        run_txn("sat_h2", 32'h0000_0200, 1, 1, 0, 32'h0, '0, 0, 0, '0, 0, 0);
        run_txn("sat_h3", 32'h0000_0300, 0, 1, 0, 32'h0, '0, 0, 0, '0, 0, 0);
        run_txn("sat_h4", 32'h0000_0400, 1, 0, 0, 32'h0, '0, 0, 0, '0, 0, 0);
        check32("sat_hit_literal", 32'(s_hit_cnt), 32'd3);
        check32("wide_hit_literal", hit_cnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            run_txn("sat_miss", 32'h0000_A000 + 32'(i * 32), 0, 0, 0, 32'h0, '0, 0, 0,
                    {8{32'(i + 1)}}, 0, 0);
        end
        check32("sat_miss_literal", 32'(s_miss_cnt), 32'd3);
        check32("wide_miss_literal", miss_cnt, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
